dffram512x32_arb2: RTL

//  Two-requester arbiter/sequencer sharing one single-port 512x32 DFFRAM macro
//  (CLK, WE0[3:0], EN0, A0[8:0], Di0[31:0], Do0[31:0]). Typical use: port 0 =

---
 rtl/dffram512x32_arb2.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dffram512x32_arb2.sv
// Two-port round-robin arbiter with burst quota in front of one 512x32 DFFRAM.
// Define DFFRAM_ARB_RDATA_REG_EN to register read data (read latency 2).
module dffram512x32_arb2 #(
    parameter int MAX_BURST = 4,
    parameter int AW        = 9,
    parameter int DW        = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              p0_req,
    input  logic [DW/8-1:0]   p0_we,
    input  logic [AW-1:0]     p0_a,
    input  logic [DW-1:0]     p0_di,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DW-1:0]     p0_do,
    input  logic              p1_req,
    input  logic [DW/8-1:0]   p1_we,
    input  logic [AW-1:0]     p1_a,
    input  logic [DW-1:0]     p1_di,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DW-1:0]     p1_do,
    output logic              ram_en0,
    output logic [DW/8-1:0]   ram_we0,
    output logic [AW-1:0]     ram_a0,
    output logic [DW-1:0]     ram_di0,
    input  logic [DW-1:0]     ram_do0
);

    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } own_t;

    own_t       owner;
    logic       last_win;
    logic [3:0] cnt;

    logic       any;
    logic       pick1;
    logic       at_quota;
    logic       same_port;
    logic       rd0;
    logic       rd1;

    assign at_quota = (cnt >= MAXB);

    // Pick a winner; the burst owner keeps the RAM until its quota runs out.
    always_comb begin
        any   = 1'b0;
        pick1 = 1'b0;
        unique case ({p0_req, p1_req})
            2'b11: begin
                any = 1'b1;
                if (at_quota)
                    pick1 = ~last_win;
                else if (owner != OWN_NONE)
                    pick1 = last_win;
                else
                    pick1 = ~last_win;
            end
            2'b10: begin
                any   = 1'b1;
                pick1 = 1'b0;
            end
            2'b01: begin
                any   = 1'b1;
                pick1 = 1'b1;
            end
            default: begin
                any   = 1'b0;
                pick1 = 1'b0;
            end
        endcase
    end

    // Reset holds both grants low even while requests are up.
    assign p0_gnt = RST_N & any & ~pick1;
    assign p1_gnt = RST_N & any & pick1;

    assign ram_en0 = p0_gnt | p1_gnt;

    // Only the granted port's payload is steered onto the macro pins.
    always_comb begin
        ram_we0 = '0;
        ram_a0  = '0;
        ram_di0 = '0;
        if (p1_gnt) begin
            ram_we0 = p1_we;
            ram_a0  = p1_a;
            ram_di0 = p1_di;
        end else if (p0_gnt) begin
            ram_we0 = p0_we;
            ram_a0  = p0_a;
            ram_di0 = p0_di;
        end
    end

    assign same_port = (owner == (pick1 ? OWN_P1 : OWN_P0));

    // Track owner, last winner and the consecutive-grant counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            owner    <= OWN_NONE;
            last_win <= 1'b1;
            cnt      <= 4'd0;
        end else if (!ram_en0) begin
            owner <= OWN_NONE;
            cnt   <= 4'd0;
        end else begin
            last_win <= pick1;
            owner    <= pick1 ? OWN_P1 : OWN_P0;
            if (same_port)
                cnt <= at_quota ? MAXB : cnt + 4'd1;
            else
                cnt <= 4'd1;
        end
    end

    assign rd0 = p0_gnt & (p0_we == '0);
    assign rd1 = p1_gnt & (p1_we == '0);

`ifdef DFFRAM_ARB_RDATA_REG_EN

    logic          rv0_s1;
    logic          rv1_s1;
    logic          rv0_q;
    logic          rv1_q;
    logic [DW-1:0] rdata_q;

    // Two-deep valid pipeline; macro output is captured one cycle after the read.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rv0_s1  <= 1'b0;
            rv1_s1  <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            rv0_s1 <= rd0;
            rv1_s1 <= rd1;
            rv0_q  <= rv0_s1;
            rv1_q  <= rv1_s1;
            if (rv0_s1 | rv1_s1)
                rdata_q <= ram_do0;
        end
    end

    assign p0_rvalid = rv0_q;
    assign p1_rvalid = rv1_q;
    assign p0_do     = rdata_q;
    assign p1_do     = rdata_q;

`else

    logic rv0_q;
    logic rv1_q;

    // One-deep valid pipeline matching the macro's synchronous read.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            rv0_q <= rd0;
            rv1_q <= rd1;
        end
    end

    assign p0_rvalid = rv0_q;
    assign p1_rvalid = rv1_q;
    assign p0_do     = ram_do0;
    assign p1_do     = ram_do0;

`endif

endmodule
